data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
Shares the single-ported DataMemory between two requesters:
- the pipeline MEM stage (port P), which has priority;
- a secondary load/store master (port D), such as a debug loader or DMA.

The arbiter sits between the MEM stage and DataMemory. It grants at most one access per cycle, stalls the losing requester, and returns read data through per-port holding registers. A starvation counter guarantees port D forward progress.

Parameters:
ADDR_W, 32, address width of both ports and of the memory.
DATA_W, 32, data width.
MAX_WAIT, 4, consecutive denied cycles for D before D is forced a grant (legal range 1..15).

Ports:
Clk  in  1  clock; all state updates on the rising edge.
Rst  in  1  synchronous, active-high reset.
P_Req  in  1  pipeline access request; held until the cycle in which P_Stall=0.
P_Write  in  1  1=write, 0=read.
P_Addr  in  ADDR_W  pipeline address.
P_WData  in  DATA_W  pipeline write data.
P_Stall  out  1  P_Req & ~grant_p (combinational); freezes the pipeline.
P_Valid  out  1  one-cycle pulse: P_RData holds the read result.
P_RData  out  DATA_W  registered read data for P.
D_Req  in  1  secondary request; held until D_Gnt.
D_Write  in  1  1=write, 0=read.
D_Addr  in  ADDR_W  secondary address.
D_WData  in  DATA_W  secondary write data.
D_Gnt  out  1  grant_d (combinational); access performed this cycle.
D_Valid  out  1  one-cycle pulse: D_RData holds the read result.
D_RData  out  DATA_W  registered read data for D.
Mem_Addr  out  ADDR_W  to DataMemory address.
Mem_WData  out  DATA_W  to DataMemory write data.
Mem_Write  out  1  to DataMemory MemWrite.
Mem_Read  out  1  to DataMemory MemRead.
Mem_RData  in  DATA_W  DataMemory read data; combinational, valid in the same cycle as Mem_Read.

Behaviour:
- FSM, registered, 2 states: NORMAL and FORCE_D.
- Grant in NORMAL:
  - grant_p = P_Req.
  - grant_d = D_Req & ~P_Req.
- Grant in FORCE_D:
  - grant_d = D_Req.
  - grant_p = P_Req & ~D_Req.
- Grants are never simultaneous. When Rst=1, both grants are 0.
- Memory bus:
  - Mem_* is driven from the granted port: Mem_Read = ~Write, Mem_Write = Write.
  - With no grant, Mem_Addr/Mem_WData/Mem_Write/Mem_Read are all 0.
- wait_cnt (4-bit):
  - Clears when D_Req=0 or grant_d=1.
  - Otherwise increments, saturating at MAX_WAIT.
- State transitions:
  - NORMAL -> FORCE_D when D_Req & ~grant_d and wait_cnt+1 == MAX_WAIT.
  - FORCE_D -> NORMAL on grant_d, or when D_Req=0.
  - FORCE_D with D_Req=1 always grants D in that cycle.
- Read return:
  - On a granted read, Mem_RData is captured into that port's RData register at the end of the grant cycle.
  - The port's Valid is 1 for exactly the next cycle, so read latency is 1 cycle after grant.
  - Each RData register holds its value until the next read on the same port.
  - Writes produce no Valid.
- Back-to-back: P may be granted every cycle. Valid pulses occur on consecutive cycles and track grants one-for-one.
- Write-then-read, same address, different ports in consecutive cycles: the read returns the newly written data. Memory ordering equals grant order.
- Reset:
  - State=NORMAL, wait_cnt=0, P_Valid=D_Valid=0, P_RData=D_RData=0.
  - D_Gnt=0 and P_Stall=P_Req during Rst.
  - Rst in the cycle after a granted read suppresses that Valid.
  - Rst in a grant cycle blocks the memory access, because the grants are 0.
- Requester signal changes while not granted are legal. The arbiter samples only in the grant cycle.
- No combinational path from Mem_RData to any output.

Test Plan:
1. Reset: hold Rst=1 for 2 cycles with P_Req=D_Req=1 -> Mem_Write=Mem_Read=0, D_Gnt=0, P_Stall=1. After release, P_Valid=D_Valid=0 and both RData=0.
2. P read alone, P_Addr=0x10 with memory[0x10]=0xDEADBEEF -> same cycle Mem_Read=1, Mem_Addr=0x10, P_Stall=0. Next cycle P_Valid=1, P_RData=0xDEADBEEF. Following cycle P_Valid=0.
3. Starvation, MAX_WAIT=4, P_Req and D_Req both held high:
   - cycles 0-3: P granted, D_Gnt=0.
   - cycle 4: D_Gnt=1, P_Stall=1, state FORCE_D.
   - cycle 5: P granted again, wait_cnt=0.
4. D write alone, D_Addr=0x20, D_WData=0x12345678 -> D_Gnt=1, Mem_Write=1, Mem_WData=0x12345678, no D_Valid. A P read of 0x20 in the next cycle returns 0x12345678.
5. Counter clear: D denied for 3 cycles (MAX_WAIT=4), then D_Req=0 for 1 cycle, then D_Req=1 with P_Req held high -> D is next granted only after 4 further denied cycles.
6. Reset mid-read: P read granted in cycle n, Rst=1 in cycle n+1 -> P_Valid=0 in cycle n+1, P_RData=0 after the reset.

Source files
------------

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Shares a single-ported DataMemory between the pipeline MEM
//               stage (port P, priority) and a secondary load/store master
//               (port D). At most one access is granted per cycle. A
//               starvation counter forces a D grant after MAX_WAIT
//               consecutive denials. Read data returns through per-port
//               holding registers one cycle after the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4    // legal range 1..15
) (
  input  logic              Clk,
  input  logic              Rst,
  // pipeline port
  input  logic              P_Req,
  input  logic              P_Write,
  input  logic [ADDR_W-1:0] P_Addr,
  input  logic [DATA_W-1:0] P_WData,
  output logic              P_Stall,
  output logic              P_Valid,
  output logic [DATA_W-1:0] P_RData,
  // secondary port
  input  logic              D_Req,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D_WData,
  output logic              D_Gnt,
  output logic              D_Valid,
  output logic [DATA_W-1:0] D_RData,
  // DataMemory side
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  output logic              Mem_Write,
  output logic              Mem_Read,
  input  logic [DATA_W-1:0] Mem_RData
);

  typedef enum logic [0:0] {
    ST_NORMAL  = 1'b0,
    ST_FORCE_D = 1'b1
  } state_t;

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                p_valid_q, p_valid_d;
  logic                d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_p;
  logic                grant_d;

  // Grant selection: P wins in NORMAL, D wins in FORCE_D; nothing during reset.
  always_comb begin
    grant_p = 1'b0;
    grant_d = 1'b0;
    if (!Rst) begin
      if (state_q == ST_FORCE_D) begin
        grant_d = D_Req;
        grant_p = P_Req & ~D_Req;
      end else begin
        grant_p = P_Req;
        grant_d = D_Req & ~P_Req;
      end
    end
  end

  // Memory bus mux: follows the granted port, idles at all-zero otherwise.
  always_comb begin
    Mem_Addr  = '0;
    Mem_WData = '0;
    Mem_Write = 1'b0;
    Mem_Read  = 1'b0;
    if (grant_p) begin
      Mem_Addr  = P_Addr;
      Mem_WData = P_WData;
      Mem_Write = P_Write;
      Mem_Read  = ~P_Write;
    end else if (grant_d) begin
      Mem_Addr  = D_Addr;
      Mem_WData = D_WData;
      Mem_Write = D_Write;
      Mem_Read  = ~D_Write;
    end
  end

  // Next-state logic: starvation counter, FSM and read-return capture.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    p_valid_d  = grant_p & ~P_Write;
    d_valid_d  = grant_d & ~D_Write;
    p_rdata_d  = p_rdata_q;
    d_rdata_d  = d_rdata_q;

    // Count consecutive denied D cycles, saturating at the force threshold.
    if (!D_Req || grant_d) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < C_MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // FORCE_D is entered after the MAX_WAIT-th denial and lasts one grant.
    case (state_q)
      ST_NORMAL: begin
        if (D_Req && !grant_d && ((wait_cnt_q + 4'd1) == C_MAX_WAIT)) begin
          state_d = ST_FORCE_D;
        end
      end
      ST_FORCE_D: begin
        if (grant_d || !D_Req) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (grant_p && !P_Write) begin
      p_rdata_d = Mem_RData;
    end
    if (grant_d && !D_Write) begin
      d_rdata_d = Mem_RData;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= 4'd0;
      p_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      p_valid_q  <= p_valid_d;
      d_valid_q  <= d_valid_d;
      p_rdata_q  <= p_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Reset in the cycle after a granted read must hide that pending Valid,
  // so the Valid flops are qualified by the live reset.
  assign P_Stall = P_Req & ~grant_p;
  assign D_Gnt   = grant_d;
  assign P_Valid = p_valid_q & ~Rst;
  assign D_Valid = d_valid_q & ~Rst;
  assign P_RData = p_rdata_q;
  assign D_RData = d_rdata_q;

endmodule
`default_nettype wire
